// File: rtl/n4_ms_c2_arbiter.sv
// n4_ms_c2_arbiter: one 4-bit sign-magnitude to two's-complement
// converter shared by two req/ack requesters, result on valid/ready
`timescale 1ns/1ps

module n4_ms_c2_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic       clock,
  input  logic       reset_,
  input  logic       a_req,
  input  logic [3:0] a_abs,
  input  logic       a_sgn,
  output logic       a_ack,
  input  logic       b_req,
  input  logic [3:0] b_abs,
  input  logic       b_sgn,
  output logic       b_ack,
  output logic [3:0] z3_z0,
  output logic       ow,
  output logic       z_src,
  output logic       z_valid,
  input  logic       z_ready
);

  typedef struct packed {
    logic [3:0] mag;
    logic       sgn;
  } op_t;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    OUT
  } state_t;

  state_t     state;
  op_t        op;
  logic       last_b;
  logic       pick_b;
  logic [3:0] cz;
  logic       cow;

  // choose B when it alone requests, or on a tie when A went last
  always_comb begin
    pick_b = 1'b0;
    unique case (1'b1)
      (a_req && b_req): pick_b = FIXED_PRIO ? 1'b0 : ~last_b;
      (b_req && !a_req): pick_b = 1'b1;
      default: pick_b = 1'b0;
    endcase
  end

  // the shared converter: negate magnitude when sign is set
  always_comb begin
    cz = op.mag;
    if (op.sgn) begin
      cz = ~op.mag + 4'd1;
    end
    cow = op.mag[3] & ~(op.sgn & (op.mag[2:0] == 3'b000));
  end

  // grant, convert, then hold the result until the consumer takes it
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state   <= IDLE;
      a_ack   <= 1'b0;
      b_ack   <= 1'b0;
      z_valid <= 1'b0;
      z3_z0   <= 4'b0000;
      ow      <= 1'b0;
      z_src   <= 1'b0;
      op      <= '0;
      last_b  <= 1'b1;
    end else begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (a_req || b_req) begin
            op.mag <= pick_b ? b_abs : a_abs;
            op.sgn <= pick_b ? b_sgn : a_sgn;
            z_src  <= pick_b;
            last_b <= pick_b;
            a_ack  <= ~pick_b;
            b_ack  <= pick_b;
            state  <= CONV;
          end
        end
        CONV: begin
          z3_z0   <= cz;
          ow      <= cow;
          z_valid <= 1'b1;
          state   <= OUT;
        end
        OUT: begin
          if (z_ready) begin
            z_valid <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_n4_ms_c2_arbiter.sv
// tb_n4_ms_c2_arbiter: random requesters and consumer against a
// transaction-level model, both arbitration modes side by side
`timescale 1ns/1ps

module tb_n4_ms_c2_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] a_req, b_req, a_sgn, b_sgn, z_ready;
  logic [3:0] a_abs [2];
  logic [3:0] b_abs [2];
  logic [1:0] a_ack, b_ack, ow, z_src, z_valid;
  logic [3:0] z3_z0 [2];

  int total, bad;
  int ph [2];
  int last [2];
  int ez [2];
  int eow [2];
  int esrc [2];
  int stall [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    n4_ms_c2_arbiter #(
      .FIXED_PRIO(g == 1)
    ) u_dut (
      .clock  (clk),
      .reset_ (rst_n),
      .a_req  (a_req[g]),
      .a_abs  (a_abs[g]),
      .a_sgn  (a_sgn[g]),
      .a_ack  (a_ack[g]),
      .b_req  (b_req[g]),
      .b_abs  (b_abs[g]),
      .b_sgn  (b_sgn[g]),
      .b_ack  (b_ack[g]),
      .z3_z0  (z3_z0[g]),
      .ow     (ow[g]),
      .z_src  (z_src[g]),
      .z_valid(z_valid[g]),
      .z_ready(z_ready[g])
    );
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  // signed value of the operand, then wrap to 4 bits
  function automatic void expect_res(input int d, input int src,
                                     input logic [3:0] m, input logic s);
    int v;
    v = s ? -int'(m) : int'(m);
    ez[d]   = v & 15;
    eow[d]  = (v > 7 || v < -8) ? 1 : 0;
    esrc[d] = src;
  endfunction

  function automatic logic [4:0] rand_op();
    case ($urandom_range(9))
      0: return {4'b0101, 1'b1};
      1: return {4'b1000, 1'b1};
      2: return {4'b1000, 1'b0};
      3: return {4'b1111, 1'b1};
      4: return {4'b0000, 1'b1};
      default: return 5'($urandom);
    endcase
  endfunction

  task automatic chk_reset(input int d, input string w);
    string p;
    p = $sformatf("%s dut%0d", w, d);
    chk({p, " a_ack"}, int'(a_ack[d]), 0);
    chk({p, " b_ack"}, int'(b_ack[d]), 0);
    chk({p, " z_valid"}, int'(z_valid[d]), 0);
    chk({p, " z3_z0"}, int'(z3_z0[d]), 0);
    chk({p, " ow"}, int'(ow[d]), 0);
    chk({p, " z_src"}, int'(z_src[d]), 0);
  endtask

  // advance the model over the edge just passed, compare, drive next
  task automatic step(input int d, input bit skip);
    int g;
    bit gnt;
    string p;
    logic [4:0] o;
    p = $sformatf("dut%0d", d);
    gnt = 1'b0;
    g = 0;
    if (!skip) begin
      case (ph[d])
        0: begin
          if (a_req[d] || b_req[d]) begin
            gnt = 1'b1;
            if (a_req[d] && b_req[d]) g = (d == 1) ? 0 : 1 - last[d];
            else g = b_req[d] ? 1 : 0;
            last[d] = g;
            if (g == 0) expect_res(d, 0, a_abs[d], a_sgn[d]);
            else expect_res(d, 1, b_abs[d], b_sgn[d]);
            ph[d] = 1;
          end
        end
        1: ph[d] = 2;
        default: if (z_ready[d]) ph[d] = 0;
      endcase
    end
    chk({p, " a_ack"}, int'(a_ack[d]), int'(gnt && g == 0));
    chk({p, " b_ack"}, int'(b_ack[d]), int'(gnt && g == 1));
    chk({p, " z_valid"}, int'(z_valid[d]), int'(ph[d] == 2));
    if (ph[d] == 2) begin
      chk({p, " z3_z0"}, int'(z3_z0[d]), ez[d]);
      chk({p, " ow"}, int'(ow[d]), eow[d]);
      chk({p, " z_src"}, int'(z_src[d]), esrc[d]);
    end
    if (a_ack[d]) a_req[d] = 1'b0;
    else if (!a_req[d] && $urandom_range(3) != 0) begin
      o = rand_op();
      a_req[d] = 1'b1;
      a_abs[d] = o[4:1];
      a_sgn[d] = o[0];
    end
    if (b_ack[d]) b_req[d] = 1'b0;
    else if (!b_req[d] && $urandom_range(3) != 0) begin
      o = rand_op();
      b_req[d] = 1'b1;
      b_abs[d] = o[4:1];
      b_sgn[d] = o[0];
    end
    if (stall[d] > 0) begin
      z_ready[d] = 1'b0;
      stall[d]--;
    end else if ($urandom_range(29) == 0) begin
      z_ready[d] = 1'b0;
      stall[d] = 9;
    end else begin
      z_ready[d] = ($urandom_range(3) != 0);
    end
  endtask

  // pull reset while dut0 sits in the target phase, check at once
  task automatic reset_in(input int target);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) step(d, 1'b0);
      n++;
    end while (ph[0] != target && n < 300);
    chk("reach_phase", ph[0], target);
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk_reset(d, "async_rst");
      ph[d] = 0;
      last[d] = 1;
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) step(d, 1'b1);
    rst_n = 1'b1;
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    a_req = '0;
    b_req = '0;
    a_sgn = '0;
    b_sgn = '0;
    z_ready = '0;
    for (int d = 0; d < 2; d++) begin
      a_abs[d] = 4'd0;
      b_abs[d] = 4'd0;
      ph[d] = 0;
      last[d] = 1;
      stall[d] = 0;
    end
    #3;
    for (int d = 0; d < 2; d++) chk_reset(d, "por");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (1500) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) step(d, 1'b0);
    end
    reset_in(1);
    reset_in(2);
    repeat (400) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) step(d, 1'b0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
